// File: rtl/bnn_layer_seq.sv
// bnn_layer_seq: per-layer sequencer for the BNN XNOR-popcount datapath.
// For the selected layer it sweeps every neuron and every packed input word of that neuron.
// It issues weight/activation reads, clears and enables the accumulator, and commits each
// neuron bit. A one-cycle done pulse marks the end of the layer.
// Optional feature: define BNN_LAYER_SEQ_PERF_EN to enable the cycle_count run counter.
// With the macro undefined, no counter register exists and cycle_count is tied to 0.
module bnn_layer_seq #(
    parameter int unsigned L1_NEURONS = 256,
    parameter int unsigned L1_WORDS   = 49,
    parameter int unsigned L2_NEURONS = 128,
    parameter int unsigned L2_WORDS   = 16,
    parameter int unsigned L3_NEURONS = 10,
    parameter int unsigned L3_WORDS   = 8,
    parameter int unsigned L2_W_BASE  = 12544,
    parameter int unsigned L3_W_BASE  = 14592,
    parameter int unsigned W_ADDR_W   = 14,
    parameter int unsigned X_ADDR_W   = 6,
    parameter int unsigned N_W        = 8,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          layer,
    output logic                busy,
    output logic                rd_en,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic [X_ADDR_W-1:0] x_addr,
    output logic                acc_clr,
    output logic                acc_en,
    output logic                out_we,
    output logic [N_W-1:0]      out_idx,
    output logic                done,
    output logic [31:0]         cycle_count
);

    localparam int unsigned DRN_W = 2;

    // Per-layer configuration; counts are stored as last-index values so they fit the counter widths
    localparam logic [N_W-1:0]      L1_NLAST = N_W'(L1_NEURONS - 1);
    localparam logic [N_W-1:0]      L2_NLAST = N_W'(L2_NEURONS - 1);
    localparam logic [N_W-1:0]      L3_NLAST = N_W'(L3_NEURONS - 1);
    localparam logic [X_ADDR_W-1:0] L1_WLAST = X_ADDR_W'(L1_WORDS - 1);
    localparam logic [X_ADDR_W-1:0] L2_WLAST = X_ADDR_W'(L2_WORDS - 1);
    localparam logic [X_ADDR_W-1:0] L3_WLAST = X_ADDR_W'(L3_WORDS - 1);
    localparam logic [W_ADDR_W-1:0] L1_BASE  = W_ADDR_W'(0);
    localparam logic [W_ADDR_W-1:0] L2_BASE  = W_ADDR_W'(L2_W_BASE);
    localparam logic [W_ADDR_W-1:0] L3_BASE  = W_ADDR_W'(L3_W_BASE);
    localparam logic [DRN_W-1:0]    DRN_LAST = DRN_W'(MEM_LAT - 1);

    // Elaboration-time legality checks on the configuration
    if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_chk_lat
        $error("bnn_layer_seq: MEM_LAT must be 1..3");
    end
    if (L1_NEURONS < 1 || longint'(L1_NEURONS) > (longint'(1) << N_W) ||
        L2_NEURONS < 1 || longint'(L2_NEURONS) > (longint'(1) << N_W) ||
        L3_NEURONS < 1 || longint'(L3_NEURONS) > (longint'(1) << N_W)) begin : g_chk_n
        $error("bnn_layer_seq: neuron count does not fit N_W");
    end
    if (L1_WORDS < 1 || longint'(L1_WORDS) > (longint'(1) << X_ADDR_W) ||
        L2_WORDS < 1 || longint'(L2_WORDS) > (longint'(1) << X_ADDR_W) ||
        L3_WORDS < 1 || longint'(L3_WORDS) > (longint'(1) << X_ADDR_W)) begin : g_chk_w
        $error("bnn_layer_seq: word count does not fit X_ADDR_W");
    end
    if (longint'(L1_NEURONS) * longint'(L1_WORDS) > (longint'(1) << W_ADDR_W) ||
        longint'(L2_W_BASE) + longint'(L2_NEURONS) * longint'(L2_WORDS) > (longint'(1) << W_ADDR_W) ||
        longint'(L3_W_BASE) + longint'(L3_NEURONS) * longint'(L3_WORDS) > (longint'(1) << W_ADDR_W))
    begin : g_chk_base
        $error("bnn_layer_seq: weight range exceeds W_ADDR_W");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        COMMIT = 3'd4,
        DONE   = 3'd5
    } state_e;

    state_e                state_q,   state_d;
    logic [N_W-1:0]        nlast_q,   nlast_d;
    logic [X_ADDR_W-1:0]   wlast_q,   wlast_d;
    logic [N_W-1:0]        n_q,       n_d;
    logic [DRN_W-1:0]      drn_q,     drn_d;
    logic [W_ADDR_W-1:0]   w_addr_q,  w_addr_d;
    logic [X_ADDR_W-1:0]   x_addr_q,  x_addr_d;
    logic [N_W-1:0]        out_idx_q, out_idx_d;
    logic                  busy_q,    busy_d;
    logic                  rd_en_q,   rd_en_d;
    logic                  acc_clr_q, acc_clr_d;
    logic                  out_we_q,  out_we_d;
    logic                  done_q,    done_d;
    logic [MEM_LAT-1:0]    acc_sr_q,  acc_sr_d;

    // Next-state, counter and strobe logic; strobes are decoded from the next state so they register in step with it
    always_comb begin
        state_d   = state_q;
        nlast_d   = nlast_q;
        wlast_d   = wlast_q;
        n_d       = n_q;
        drn_d     = drn_q;
        w_addr_d  = w_addr_q;
        x_addr_d  = x_addr_q;
        out_idx_d = out_idx_q;

        case (state_q)
            IDLE: begin
                if (start && (layer != 2'd0)) begin
                    state_d  = CLEAR;
                    n_d      = '0;
                    x_addr_d = '0;
                    case (layer)
                        2'd1: begin
                            nlast_d  = L1_NLAST;
                            wlast_d  = L1_WLAST;
                            w_addr_d = L1_BASE;
                        end
                        2'd2: begin
                            nlast_d  = L2_NLAST;
                            wlast_d  = L2_WLAST;
                            w_addr_d = L2_BASE;
                        end
                        default: begin
                            nlast_d  = L3_NLAST;
                            wlast_d  = L3_WLAST;
                            w_addr_d = L3_BASE;
                        end
                    endcase
                end
            end
            CLEAR: begin
                state_d = STREAM;
            end
            STREAM: begin
                // Weight address runs contiguously across neurons: base + n*W + w
                w_addr_d = w_addr_q + W_ADDR_W'(1);
                if (x_addr_q == wlast_q) begin
                    state_d = DRAIN;
                    drn_d   = '0;
                end else begin
                    x_addr_d = x_addr_q + X_ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    state_d = COMMIT;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            COMMIT: begin
                if (n_q == nlast_q) begin
                    state_d = DONE;
                end else begin
                    n_d      = n_q + N_W'(1);
                    x_addr_d = '0;
                    state_d  = CLEAR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d == CLEAR) || (state_d == STREAM) ||
                    (state_d == DRAIN) || (state_d == COMMIT);
        rd_en_d   = (state_d == STREAM);
        acc_clr_d = (state_d == CLEAR);
        out_we_d  = (state_d == COMMIT);
        done_d    = (state_d == DONE);
        if (state_d == COMMIT) begin
            out_idx_d = n_q;
        end

        // acc_en is rd_en delayed by exactly MEM_LAT cycles
        acc_sr_d = MEM_LAT'({acc_sr_q, rd_en_q});
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            nlast_q   <= '0;
            wlast_q   <= '0;
            n_q       <= '0;
            drn_q     <= '0;
            w_addr_q  <= '0;
            x_addr_q  <= '0;
            out_idx_q <= '0;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            acc_clr_q <= 1'b0;
            out_we_q  <= 1'b0;
            done_q    <= 1'b0;
            acc_sr_q  <= '0;
        end else begin
            state_q   <= state_d;
            nlast_q   <= nlast_d;
            wlast_q   <= wlast_d;
            n_q       <= n_d;
            drn_q     <= drn_d;
            w_addr_q  <= w_addr_d;
            x_addr_q  <= x_addr_d;
            out_idx_q <= out_idx_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            acc_clr_q <= acc_clr_d;
            out_we_q  <= out_we_d;
            done_q    <= done_d;
            acc_sr_q  <= acc_sr_d;
        end
    end

`ifdef BNN_LAYER_SEQ_PERF_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    // Run-length counter: cleared on accepted start, counts busy cycles, holds after done
    always_comb begin
        cycle_count_d = cycle_count_q;
        if ((state_q == IDLE) && (state_d == CLEAR)) begin
            cycle_count_d = '0;
        end else if (busy_q) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    // Run-length counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
`else
    assign cycle_count = 32'd0;
`endif

    assign busy    = busy_q;
    assign rd_en   = rd_en_q;
    assign w_addr  = w_addr_q;
    assign x_addr  = x_addr_q;
    assign acc_clr = acc_clr_q;
    assign acc_en  = acc_sr_q[MEM_LAT-1];
    assign out_we  = out_we_q;
    assign out_idx = out_idx_q;
    assign done    = done_q;

endmodule
